// File: rtl/rf_arb_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package rf_arb_pkg;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = 5;
    localparam int DW_DEF   = 32;

    typedef logic [AW_DEF-1:0] reg_addr_t;
    typedef logic [DW_DEF-1:0] word_t;

    typedef enum logic {S_NORM, S_BOOST} arb_state_e;
    typedef enum logic {SRC_P0, SRC_P1} src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy vector of registers reserved by in-flight multi-cycle ops.
// Register 0 can never be reserved; a set and a clear of the same register in one cycle leave it set.
module rf_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // Clear is applied first so that a same-cycle set takes precedence.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy1 = busy[ra1];
    assign busy2 = busy[ra2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline (P0) and multi-cycle (P1) writeback.
// Build option RF_WB_ARB_RR_EN: round-robin on conflict instead of P0 priority with a starvation boost.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREG       = NREG_DEF,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    output logic          p0_ready,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_data,
    input  logic          p1_valid,
    output logic          p1_ready,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_data,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    logic          p1_pri;
    logic          xfer;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;
    src_e          win_src;
    src_e          wr_src;

`ifdef RF_WB_ARB_RR_EN
    src_e last_grant;

    // Starts at P1 so the first conflict after reset goes to P0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= SRC_P1;
        end else if (p0_ready) begin
            last_grant <= SRC_P0;
        end else if (p1_ready) begin
            last_grant <= SRC_P1;
        end
    end

    assign p1_pri = (last_grant == SRC_P0);
`else
    localparam int CW = $clog2(STARVE_MAX + 1);

    arb_state_e    state;
    arb_state_e    state_nxt;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_NORM;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Denials accumulate (saturating); enough of them in a row boost P1 until it is served.
    always_comb begin
        state_nxt  = state;
        starve_nxt = '0;
        if (p1_valid && !p1_ready) begin
            starve_nxt = (starve_cnt == CW'(STARVE_MAX)) ? starve_cnt : starve_cnt + CW'(1);
        end
        case (state)
            S_NORM: begin
                if (p1_valid && !p1_ready && starve_nxt == CW'(STARVE_MAX)) begin
                    state_nxt = S_BOOST;
                end
            end
            S_BOOST: begin
                if (p1_ready) begin
                    state_nxt = S_NORM;
                end
            end
            default: state_nxt = S_NORM;
        endcase
    end

    always_comb begin
        p1_pri = (state == S_BOOST);
    end
`endif

    // Readys are forced low during reset; p1_pri only matters when both request.
    always_comb begin
        p0_ready = 1'b0;
        p1_ready = 1'b0;
        if (!rst) begin
            if (p0_valid && p1_valid) begin
                p0_ready = !p1_pri;
                p1_ready = p1_pri;
            end else begin
                p0_ready = p0_valid;
                p1_ready = p1_valid;
            end
        end
    end

    always_comb begin
        xfer     = p0_ready || p1_ready;
        win_addr = p1_ready ? p1_addr : p0_addr;
        win_data = p1_ready ? p1_data : p0_data;
        win_src  = p1_ready ? SRC_P1 : SRC_P0;
    end

    // Writes to register 0 complete the handshake but never assert the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            wr_src <= SRC_P0;
        end else begin
            rf_we <= xfer && (win_addr != '0);
            if (xfer) begin
                rf_wa  <= win_addr;
                rf_wd  <= win_data;
                wr_src <= win_src;
            end
        end
    end

    rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_valid),
        .set_addr (issue_addr),
        .clr_en   (rf_we && (wr_src == SRC_P1)),
        .clr_addr (rf_wa),
        .ra1      (ra1),
        .ra2      (ra2),
        .busy1    (busy1),
        .busy2    (busy2)
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default build, or round-robin when RF_WB_ARB_RR_EN is defined).
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_valid;
    logic        p0_ready;
    logic [4:0]  p0_addr;
    logic [31:0] p0_data;
    logic        p1_valid;
    logic        p1_ready;
    logic [4:0]  p1_addr;
    logic [31:0] p1_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        busy1;
    logic        busy2;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int tests_run;
    int tests_failed;

    rf_wb_arbiter #(
        .NREG       (32),
        .AW         (5),
        .DW         (32),
        .STARVE_MAX (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .p0_valid    (p0_valid),
        .p0_ready    (p0_ready),
        .p0_addr     (p0_addr),
        .p0_data     (p0_data),
        .p1_valid    (p1_valid),
        .p1_ready    (p1_ready),
        .p1_addr     (p1_addr),
        .p1_data     (p1_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy1       (busy1),
        .busy2       (busy2),
        .rf_we       (rf_we),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic p0v, input logic [4:0] p0a, input logic [31:0] p0d,
                                 input logic p1v, input logic [4:0] p1a, input logic [31:0] p1d,
                                 input logic iv, input logic [4:0] ia);
        p0_valid    = p0v;
        p0_addr     = p0a;
        p0_data     = p0d;
        p1_valid    = p1v;
        p1_addr     = p1a;
        p1_data     = p1d;
        issue_valid = iv;
        issue_addr  = ia;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_p1;
        tests_run    = 0;
        tests_failed = 0;
        ra1 = 5'd0;
        ra2 = 5'd0;

        // Reset held with both requesters active
        rst = 1'b1;
        applyStimulus(1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'h5555, 1'b0, 5'd0);
        #2;
        checkOutput("rst_p0_ready", p0_ready, 0);
        checkOutput("rst_p1_ready", p1_ready, 0);
        checkOutput("rst_rf_we", rf_we, 0);
        checkOutput("rst_busy1", busy1, 0);
        checkOutput("rst_busy2", busy2, 0);
        cycle();
        cycle();
        checkOutput("rst_rf_we_edge", rf_we, 0);
        checkOutput("rst_rf_wa", rf_wa, 0);
        checkOutput("rst_rf_wd", rf_wd, 0);
        rst = 1'b0;
        #1;

        // Conflict: P0 first, then P1
        checkOutput("conf_p0_ready", p0_ready, 1);
        checkOutput("conf_p1_ready", p1_ready, 0);
        cycle();
        checkOutput("conf_we0", rf_we, 1);
        checkOutput("conf_wa0", rf_wa, 3);
        checkOutput("conf_wd0", rf_wd, 32'hAAAA);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h5555, 1'b0, 5'd0);
        #1;
        checkOutput("conf_p1_ready2", p1_ready, 1);
        checkOutput("conf_p0_ready2", p0_ready, 0);
        cycle();
        checkOutput("conf_we1", rf_we, 1);
        checkOutput("conf_wa1", rf_wa, 4);
        checkOutput("conf_wd1", rf_wd, 32'h5555);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        cycle();
        checkOutput("idle_we", rf_we, 0);

        // Sustained conflict: starvation boost or alternation
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'd2, 32'h200 + i, 1'b0, 5'd0);
            #1;
`ifdef RF_WB_ARB_RR_EN
            exp_p1 = (i % 2 == 1);
`else
            exp_p1 = (i == 4);
`endif
            checkOutput($sformatf("starve_p1_ready_%0d", i), p1_ready, exp_p1);
            checkOutput($sformatf("starve_p0_ready_%0d", i), p0_ready, !exp_p1);
            cycle();
            checkOutput($sformatf("starve_wa_%0d", i), rf_wa, exp_p1 ? 32'd2 : 32'd1);
            checkOutput($sformatf("starve_wd_%0d", i), rf_wd, exp_p1 ? 32'h200 + i : 32'h100 + i);
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        cycle();

        // Scoreboard reserve, P0 does not clear, P1 commit clears
        ra1 = 5'd7;
        ra2 = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        #1;
        checkOutput("sb_busy1_pre", busy1, 0);
        cycle();
        applyStimulus(1'b1, 5'd7, 32'h9999, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("sb_busy1_set", busy1, 1);
        checkOutput("sb_busy2_clear", busy2, 0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("sb_p0_we", rf_we, 1);
        checkOutput("sb_p0_wa", rf_wa, 7);
        cycle();
        checkOutput("sb_p0_no_clear", busy1, 1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        #1;
        checkOutput("sb_p1_ready", p1_ready, 1);
        checkOutput("sb_p0_ready", p0_ready, 0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("sb_p1_we", rf_we, 1);
        checkOutput("sb_p1_wa", rf_wa, 7);
        checkOutput("sb_p1_wd", rf_wd, 32'h1234);
        checkOutput("sb_busy_during_commit", busy1, 1);
        cycle();
        checkOutput("sb_busy_cleared", busy1, 0);

        // Same-cycle set and clear of register 7
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h42, 1'b0, 5'd0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
        checkOutput("sw_we", rf_we, 1);
        checkOutput("sw_wa", rf_wa, 7);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("sw_set_wins", busy1, 1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h43, 1'b0, 5'd0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        cycle();
        checkOutput("sw_cleared", busy1, 0);

        // Register 0: handshake without write or reservation
        ra1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
        #1;
        checkOutput("r0_p0_ready", p0_ready, 1);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("r0_we", rf_we, 0);
        checkOutput("r0_busy", busy1, 0);

        // Reset while a write is pending
        ra2 = 5'd9;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h77, 1'b0, 5'd0);
        checkOutput("mr_busy2_set", busy2, 1);
        cycle();
        applyStimulus(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("mr_we_pending", rf_we, 1);
        rst = 1'b1;
        #1;
        checkOutput("mr_we_dropped", rf_we, 0);
        checkOutput("mr_wa_cleared", rf_wa, 0);
        checkOutput("mr_busy2_cleared", busy2, 0);
        checkOutput("mr_p0_ready_rst", p0_ready, 0);
        cycle();
        rst = 1'b0;
        #1;
        checkOutput("mr_p0_ready_after", p0_ready, 1);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        checkOutput("mr_we_after", rf_we, 1);
        checkOutput("mr_wa_after", rf_wa, 5);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
